// File: rtl/lsu_wb_pkg.sv
// ============================================================================
// Module : lsu_wb_pkg
// Brief  : Shared writeback micro-op layout and register-type encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_wb_pkg;

    localparam int WB_UOP_W = 16;

    localparam logic [1:0] RT_FIX = 2'd0;
    localparam logic [1:0] RT_FLT = 2'd1;
    localparam logic [1:0] RT_X   = 2'd2;

    // Declared MSB-first so rob_idx lands in bits [6:0].
    typedef struct packed {
        logic [1:0] dst_rtype;
        logic [6:0] pdst;
        logic [6:0] rob_idx;
    } wb_uop_t;

endpackage : lsu_wb_pkg

`default_nettype wire

// File: rtl/wb_pipe_reg.sv
// ============================================================================
// Module : wb_pipe_reg
// Brief  : Single-entry valid/ready pipeline register with full throughput.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wb_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] bits_i,
    input  logic         ready_i,
    output logic         cap_o,
    output logic         valid_o,
    output logic [W-1:0] bits_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] bits_q,  bits_d;

    // Capacity includes the drain happening this cycle, so a new beat can
    // replace the departing one without a bubble.
    assign cap_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        bits_d  = bits_q;
        if (load_i) begin
            valid_d = 1'b1;
            bits_d  = bits_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            bits_q  <= '0;
        end else begin
            valid_q <= valid_d;
            bits_q  <= bits_d;
        end
    end

    assign valid_o = valid_q;
    assign bits_o  = bits_q;

endmodule : wb_pipe_reg

`default_nettype wire

// File: rtl/lsu_wb_scheduler.sv
// ============================================================================
// Module : lsu_wb_scheduler
// Brief  : Arbitrates two LSU writeback sources onto one registered regfile
//          writeback port, with starvation override for port 1.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module lsu_wb_scheduler
    import lsu_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                io_in_0_valid,
    output logic                io_in_0_ready,
    input  logic [WB_UOP_W-1:0] io_in_0_bits_uop,
    input  logic [DATA_W-1:0]   io_in_0_bits_data,
    input  logic                io_in_1_valid,
    output logic                io_in_1_ready,
    input  logic [WB_UOP_W-1:0] io_in_1_bits_uop,
    input  logic [DATA_W-1:0]   io_in_1_bits_data,
    input  logic                io_in_1_bits_predicated,
    output logic                io_out_valid,
    input  logic                io_out_ready,
    output logic [WB_UOP_W-1:0] io_out_bits_uop,
    output logic [DATA_W-1:0]   io_out_bits_data,
    output logic                io_out_bits_predicated,
    output logic                io_starve_active
);

    localparam int C_CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int C_BEAT_W = WB_UOP_W + DATA_W + 1;

    logic [C_CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic                w_ovr;
    logic                w_cap;
    logic                w_sel1;
    logic                w_fire0, w_fire1;
    logic                w_load;
    wb_uop_t             w_sel_uop;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_pred;
    logic [C_BEAT_W-1:0] w_beat_in, w_beat_out;

    generate
        if (STARVE_LIMIT != 0) begin : g_starve
            assign w_ovr = (wait_cnt_q == C_CNT_W'(STARVE_LIMIT));
        end else begin : g_no_starve
            assign w_ovr = 1'b0;
        end
    endgenerate

    // Readies are functions of the other port's valid only, never their own.
    assign io_in_0_ready = w_cap && !(w_ovr && io_in_1_valid);
    assign io_in_1_ready = w_cap && (!io_in_0_valid || w_ovr);

    assign w_fire0 = io_in_0_valid && io_in_0_ready;
    assign w_fire1 = io_in_1_valid && io_in_1_ready;
    assign w_load  = w_fire0 || w_fire1;

    assign w_sel1     = io_in_1_valid && (!io_in_0_valid || w_ovr);
    assign w_sel_uop  = w_sel1 ? wb_uop_t'(io_in_1_bits_uop) : wb_uop_t'(io_in_0_bits_uop);
    assign w_sel_data = w_sel1 ? io_in_1_bits_data : io_in_0_bits_data;
    assign w_sel_pred = w_sel1 && io_in_1_bits_predicated;
    assign w_beat_in  = {w_sel_uop, w_sel_data, w_sel_pred};

    // Keeps counting through output stalls so the override fires the moment
    // capacity returns.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (w_fire1 || !io_in_1_valid) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < C_CNT_W'(STARVE_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    wb_pipe_reg #(
        .W (C_BEAT_W)
    ) u_out_stage (
        .clk_i   (clock),
        .rst_i   (reset),
        .load_i  (w_load),
        .bits_i  (w_beat_in),
        .ready_i (io_out_ready),
        .cap_o   (w_cap),
        .valid_o (io_out_valid),
        .bits_o  (w_beat_out)
    );

    assign {io_out_bits_uop, io_out_bits_data, io_out_bits_predicated} = w_beat_out;
    assign io_starve_active = w_ovr && io_in_1_valid;

    a_single_fire : assert property (@(posedge clock) disable iff (reset)
        !(w_fire0 && w_fire1));

    a_stall_stable : assert property (@(posedge clock) disable iff (reset)
        (io_out_valid && !io_out_ready) |=> $stable(w_beat_out));

endmodule : lsu_wb_scheduler

`default_nettype wire

// File: tb/tb_lsu_wb_scheduler.sv
// ============================================================================
// Module : tb_lsu_wb_scheduler
// Brief  : Directed scoreboard bench for lsu_wb_scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_lsu_wb_scheduler;

    typedef struct packed {
        logic [15:0] uop;
        logic [63:0] data;
        logic        pred;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in0_valid = 1'b0, in1_valid = 1'b0, in1_pred = 1'b0, out_ready = 1'b0;
    logic [15:0] in0_uop = '0, in1_uop = '0;
    logic [63:0] in0_data = '0, in1_data = '0;
    logic        in0_ready, in1_ready, out_valid, out_pred, starve;
    logic [15:0] out_uop;
    logic [63:0] out_data;

    logic        b_v0 = 1'b0, b_v1 = 1'b0, b_oready = 1'b0;
    logic [63:0] b_d0 = '0, b_d1 = '0;
    logic        b_r0, b_r1, b_ovalid, b_opred, b_starve;
    logic [15:0] b_ouop;
    logic [63:0] b_odata;

    int    checks = 0;
    int    errors = 0;
    beat_t sb_q[$];

    always #5 clock = ~clock;

    lsu_wb_scheduler #(.STARVE_LIMIT(4), .DATA_W(64)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .io_in_0_valid           (in0_valid),
        .io_in_0_ready           (in0_ready),
        .io_in_0_bits_uop        (in0_uop),
        .io_in_0_bits_data       (in0_data),
        .io_in_1_valid           (in1_valid),
        .io_in_1_ready           (in1_ready),
        .io_in_1_bits_uop        (in1_uop),
        .io_in_1_bits_data       (in1_data),
        .io_in_1_bits_predicated (in1_pred),
        .io_out_valid            (out_valid),
        .io_out_ready            (out_ready),
        .io_out_bits_uop         (out_uop),
        .io_out_bits_data        (out_data),
        .io_out_bits_predicated  (out_pred),
        .io_starve_active        (starve)
    );

    lsu_wb_scheduler #(.STARVE_LIMIT(0), .DATA_W(64)) dut0 (
        .clock                   (clock),
        .reset                   (reset),
        .io_in_0_valid           (b_v0),
        .io_in_0_ready           (b_r0),
        .io_in_0_bits_uop        (16'h0011),
        .io_in_0_bits_data       (b_d0),
        .io_in_1_valid           (b_v1),
        .io_in_1_ready           (b_r1),
        .io_in_1_bits_uop        (16'h0022),
        .io_in_1_bits_data       (b_d1),
        .io_in_1_bits_predicated (1'b1),
        .io_out_valid            (b_ovalid),
        .io_out_ready            (b_oready),
        .io_out_bits_uop         (b_ouop),
        .io_out_bits_data        (b_odata),
        .io_out_bits_predicated  (b_opred),
        .io_starve_active        (b_starve)
    );

    function automatic logic [15:0] mk_uop(logic [1:0] rt, logic [6:0] pdst, logic [6:0] rob);
        return {rt, pdst, rob};
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(logic [15:0] u, logic [63:0] d, logic p);
        beat_t b;
        b.uop  = u;
        b.data = d;
        b.pred = p;
        sb_q.push_back(b);
    endtask

    // Monitor: every accepted output beat must match the oldest expectation.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=0x%0h required=none", out_data);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                chk("mon_uop",  64'(out_uop),  64'(e.uop));
                chk("mon_data", out_data,      e.data);
                chk("mon_pred", 64'(out_pred), 64'(e.pred));
            end
        end
    end

    initial begin
        logic [9:0] pat2;
        logic       w1;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_starve",    64'(starve),    64'd0);
        chk("rst_in0_ready", 64'(in0_ready), 64'd1);
        chk("rst_in1_ready", 64'(in1_ready), 64'd1);
        chk("rst_wait_cnt",  64'(dut.wait_cnt_q), 64'd0);

        // Port 0 alone
        in0_valid = 1'b1; in0_uop = mk_uop(2'd0, 7'd0, 7'd5); in0_data = 64'hDEAD;
        out_ready = 1'b1;
        #1;
        chk("t1_in0_ready", 64'(in0_ready), 64'd1);
        push(in0_uop, 64'hDEAD, 1'b0);
        step();
        in0_valid = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_rob_idx",   64'(out_uop[6:0]), 64'd5);
        chk("t1_data",      out_data, 64'hDEAD);
        chk("t1_pred",      64'(out_pred), 64'd0);

        // Both ports for 10 cycles: port 1 wins at cycles 4 and 9
        pat2 = 10'b10_0001_0000;
        for (int c = 0; c < 10; c++) begin
            in0_valid = 1'b1; in0_uop = mk_uop(2'd0, 7'(c + 1), 7'(c));
            in0_data = 64'h100 + 64'(c);
            in1_valid = 1'b1; in1_uop = mk_uop(2'd1, 7'(8'h40 + c), 7'(8'h20 + c));
            in1_data = 64'h200 + 64'(c); in1_pred = 1'b1;
            #1;
            w1 = pat2[c];
            chk("t2_starve",    64'(starve),    64'(w1));
            chk("t2_in0_ready", 64'(in0_ready), 64'(!w1));
            chk("t2_in1_ready", 64'(in1_ready), 64'(w1));
            if (w1) push(in1_uop, in1_data, 1'b1);
            else    push(in0_uop, in0_data, 1'b0);
            step();
        end
        in0_valid = 1'b0; in1_valid = 1'b0;

        // Port 1 alone, predicated, pdst 0x3F
        for (int c = 0; c < 3; c++) begin
            in1_valid = 1'b1; in1_uop = mk_uop(2'd0, 7'h3F, 7'(8'h10 + c));
            in1_data = 64'h300 + 64'(c); in1_pred = 1'b1;
            #1;
            chk("t3_in1_ready", 64'(in1_ready), 64'd1);
            chk("t3_starve",    64'(starve),    64'd0);
            push(in1_uop, in1_data, 1'b1);
            step();
            chk("t3_out_pdst", 64'(out_uop[13:7]), 64'h3F);
            chk("t3_out_pred", 64'(out_pred), 64'd1);
        end
        in1_valid = 1'b0; in1_pred = 1'b0;

        // Load one beat, then stall for 3 cycles with both ports requesting
        in0_valid = 1'b1; in0_uop = mk_uop(2'd1, 7'd1, 7'h30); in0_data = 64'h400;
        #1;
        push(in0_uop, 64'h400, 1'b0);
        step();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in0_valid = 1'b1; in0_data = 64'h401 + 64'(s);
            in1_valid = 1'b1; in1_uop = mk_uop(2'd0, 7'h50, 7'h31); in1_data = 64'h501 + 64'(s);
            #1;
            chk("t4_in0_ready_stall", 64'(in0_ready), 64'd0);
            chk("t4_in1_ready_stall", 64'(in1_ready), 64'd0);
            chk("t4_out_valid_stall", 64'(out_valid), 64'd1);
            chk("t4_out_data_stall",  out_data, 64'h400);
            step();
        end
        chk("t4_wait_cnt3", 64'(dut.wait_cnt_q), 64'd3);
        chk("t4_out_uop_held", 64'(out_uop), 64'(mk_uop(2'd1, 7'd1, 7'h30)));
        // Resume: wait_cnt=3 lets port 0 go once more, then port 1 overrides
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            in0_data = 64'h410 + 64'(r);
            in1_data = 64'h510 + 64'(r);
            #1;
            chk("t4_starve_resume", 64'(starve), 64'(r == 1));
            if (r == 1) push(in1_uop, in1_data, 1'b0);
            else        push(in0_uop, in0_data, 1'b0);
            step();
            chk("t4_stream_valid", 64'(out_valid), 64'd1);
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();

        // Reset while a beat is held and wait_cnt is 3
        in0_valid = 1'b1; in0_data = 64'h600;
        #1;
        push(in0_uop, 64'h600, 1'b0);
        step();
        out_ready = 1'b0;
        in1_valid = 1'b1;
        repeat (3) step();
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        chk("t5_pre_wait",  64'(dut.wait_cnt_q), 64'd3);
        void'(sb_q.pop_back());
        reset = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        chk("t5_wait_cnt",  64'(dut.wait_cnt_q), 64'd0);
        chk("t5_starve",    64'(starve), 64'd0);
        reset = 1'b0; out_ready = 1'b1;
        step();

        // STARVE_LIMIT=0 build: port 1 must never win
        b_oready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            b_v0 = 1'b1; b_v1 = 1'b1;
            b_d0 = 64'h700 + 64'(c); b_d1 = 64'h800 + 64'(c);
            #1;
            chk("t6_in1_ready", 64'(b_r1),     64'd0);
            chk("t6_starve",    64'(b_starve), 64'd0);
            step();
            chk("t6_out_data",  b_odata, 64'h700 + 64'(c));
            chk("t6_out_pred",  64'(b_opred), 64'd0);
        end
        b_v0 = 1'b0; b_v1 = 1'b0;

        step();
        step();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lsu_wb_scheduler

`default_nettype wire
